// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracker feeding the decode-stage
// hazard logic. A write is recorded when its instruction is accepted into EX and
// retired when it reaches writeback; sources of the ID-stage instruction that
// still have a pending write raise stall_d.
// Optional feature macro: SCOREBOARD_STATS_EN adds the stall_cnt and
// max_pend_hit observation ports. Without it the core behaviour is unchanged.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  logic                     issue_regwrite,
  input  logic [$clog2(NREG)-1:0]  issue_wreg,
  output logic                     issue_ready,
  input  logic                     wb_valid,
  input  logic [$clog2(NREG)-1:0]  wb_wreg,
  input  logic [$clog2(NREG)-1:0]  rs_d,
  input  logic [$clog2(NREG)-1:0]  rt_d,
  input  logic                     use_rs,
  input  logic                     use_rt,
  output logic                     stall_d,
  output logic [NREG-1:0]          busy
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [0:0]               max_pend_hit
`endif
);

  localparam int IDX_W = $clog2(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] REG_ZERO = '0;

  // Per-register outstanding write count; entry 0 is held at zero forever.
  logic [NREG-1:0][CNT_W-1:0] pend_q;
  logic [NREG-1:0][CNT_W-1:0] pend_d;

  // Decoded issue / retire events.
  logic            issueWrites;
  logic            acc;
  logic            ret;
  logic [NREG-1:0] accVec;
  logic [NREG-1:0] retVec;

  // Hazard terms for the two decode-stage sources.
  logic rsPending;
  logic rtPending;
  logic rsLastRetire;
  logic rtLastRetire;
  logic hitRs;
  logic hitRt;

  // A register whose counter is saturated cannot take another in-flight write.
  always_comb begin
    issue_ready = (pend_q[issue_wreg] != CNT_MAX);
  end

  // Qualify the EX issue and the WB retire into single-cycle events.
  always_comb begin
    issueWrites = issue_valid & issue_regwrite & (issue_wreg != REG_ZERO);
    acc         = issueWrites & issue_ready;
    ret         = wb_valid & (wb_wreg != REG_ZERO) & (pend_q[wb_wreg] != '0);
  end

  // Spread the events into one-hot per-register strobes.
  always_comb begin
    accVec = '0;
    retVec = '0;
    for (int r = 1; r < NREG; r++) begin
      accVec[r] = acc & (issue_wreg == IDX_W'(r));
      retVec[r] = ret & (wb_wreg == IDX_W'(r));
    end
  end

  // Next counter values: issue adds, retire subtracts, both together cancel.
  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < NREG; r++) begin
      if (accVec[r] && !retVec[r]) begin
        pend_d[r] = pend_q[r] + CNT_ONE;
      end else if (retVec[r] && !accVec[r]) begin
        pend_d[r] = pend_q[r] - CNT_ONE;
      end
    end
    pend_d[0] = '0;
    if (flush) begin
      pend_d = '0;
    end
  end

  // Counter state register; reset outranks flush and all traffic.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // A source hazards unless its final pending write is retiring this very cycle.
  always_comb begin
    rsPending    = use_rs & (rs_d != REG_ZERO) & (pend_q[rs_d] != '0);
    rtPending    = use_rt & (rt_d != REG_ZERO) & (pend_q[rt_d] != '0);
    rsLastRetire = ret & (wb_wreg == rs_d) & (pend_q[rs_d] == CNT_ONE);
    rtLastRetire = ret & (wb_wreg == rt_d) & (pend_q[rt_d] == CNT_ONE);
    hitRs        = rsPending & ~rsLastRetire;
    hitRt        = rtPending & ~rtLastRetire;
    stall_d      = hitRs | hitRt;
  end

  // Registered busy view: one bit per register with any outstanding write.
  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = (pend_q[r] != '0);
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stallCnt_q;
  logic [31:0] stallCnt_d;
  logic        maxPendHit_q;
  logic        maxPendHit_d;

  // Stall cycle counter wraps naturally; the sticky flag notes any refused issue.
  always_comb begin
    stallCnt_d   = stall_d ? (stallCnt_q + 32'd1) : stallCnt_q;
    maxPendHit_d = maxPendHit_q | (issueWrites & ~issue_ready);
  end

  // Statistics registers survive flush and are cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCnt_q   <= '0;
      maxPendHit_q <= 1'b0;
    end else begin
      stallCnt_q   <= stallCnt_d;
      maxPendHit_q <= maxPendHit_d;
    end
  end

  assign stall_cnt    = stallCnt_q;
  assign max_pend_hit = maxPendHit_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed bench for reg_scoreboard with a count-based
// reference model checked on every cycle plus hand-computed spot checks.
module tb_reg_scoreboard;

  localparam int NREG  = 32;
  localparam int CNT_W = 2;
  localparam int PMAX  = (1 << CNT_W) - 1;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic        issue_regwrite;
  logic [4:0]  issue_wreg;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_wreg;
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic        use_rs;
  logic        use_rt;
  logic        stall_d;
  logic [31:0] busy;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [0:0]  max_pend_hit;
`endif

  int  total = 0;
  int  bad   = 0;
  int  pend[NREG];
  int  nxt[NREG];
  bit  checkEn = 0;
  logic [31:0] modelStallCnt = '0;
  bit  modelMaxHit = 0;

  reg_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_regwrite (issue_regwrite),
    .issue_wreg     (issue_wreg),
    .issue_ready    (issue_ready),
    .wb_valid       (wb_valid),
    .wb_wreg        (wb_wreg),
    .rs_d           (rs_d),
    .rt_d           (rt_d),
    .use_rs         (use_rs),
    .use_rt         (use_rt),
    .stall_d        (stall_d),
    .busy           (busy)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cnt      (stall_cnt),
    .max_pend_hit   (max_pend_hit)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Sources of an ID instruction block while any write to them stays outstanding
  // after counting a retire that lands in this same cycle.
  function automatic bit srcBlocked(input logic u, input logic [4:0] x);
    int left;
    if (!u || x == 5'd0) return 1'b0;
    left = pend[x];
    if (wb_valid && wb_wreg == x && pend[x] > 0) left = left - 1;
    return left > 0;
  endfunction

  // Reference model: compare at the falling edge, advance counts at the rising edge.
  initial begin : compareProc
    bit expReady;
    bit expStall;
    bit acc;
    bit ret;
    logic [31:0] expBusy;
    forever begin
      @(negedge clock);
      expReady = (issue_wreg == 5'd0) || (pend[issue_wreg] < PMAX);
      expStall = srcBlocked(use_rs, rs_d) || srcBlocked(use_rt, rt_d);
      expBusy  = '0;
      for (int r = 1; r < NREG; r++) expBusy[r] = (pend[r] != 0);
      if (checkEn) begin
        checkOutput("issue_ready", {31'd0, issue_ready}, {31'd0, expReady});
        checkOutput("stall_d", {31'd0, stall_d}, {31'd0, expStall});
        checkOutput("busy", busy, expBusy);
`ifdef SCOREBOARD_STATS_EN
        checkOutput("stall_cnt", stall_cnt, modelStallCnt);
        checkOutput("max_pend_hit", {31'd0, max_pend_hit}, {31'd0, modelMaxHit});
`endif
      end
      acc = issue_valid && issue_regwrite && issue_wreg != 5'd0 && pend[issue_wreg] < PMAX;
      ret = wb_valid && wb_wreg != 5'd0 && pend[wb_wreg] > 0;
      nxt = pend;
      if (acc) nxt[issue_wreg] = nxt[issue_wreg] + 1;
      if (ret) nxt[wb_wreg] = nxt[wb_wreg] - 1;
      if (reset || flush) begin
        for (int r = 0; r < NREG; r++) nxt[r] = 0;
      end
      @(posedge clock);
      pend = nxt;
      if (reset) begin
        modelStallCnt = '0;
        modelMaxHit   = 1'b0;
      end else begin
        if (expStall) modelStallCnt = modelStallCnt + 32'd1;
        if (issue_valid && issue_regwrite && !expReady) modelMaxHit = 1'b1;
      end
    end
  end

  // Drive one cycle's worth of inputs, then settle before any spot checks.
  task automatic applyStimulus(input logic rst, input logic fl,
                               input logic iv, input logic irw, input logic [4:0] iw,
                               input logic wv, input logic [4:0] ww,
                               input logic urs, input logic [4:0] rs,
                               input logic urt, input logic [4:0] rt);
    reset          = rst;
    flush          = fl;
    issue_valid    = iv;
    issue_regwrite = irw;
    issue_wreg     = iw;
    wb_valid       = wv;
    wb_wreg        = ww;
    use_rs         = urs;
    rs_d           = rs;
    use_rt         = urt;
    rt_d           = rt;
    #2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
  endtask

  initial begin : mainProc
    // Reset and initial state.
    applyStimulus(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    tick();
    checkEn = 1;
    idle();
    checkOutput("reset ready", {31'd0, issue_ready}, 32'd1);
    checkOutput("reset stall", {31'd0, stall_d}, 32'd0);
    checkOutput("reset busy", busy, 32'd0);
    tick();

    // Build up scattered pending state, then reset in the middle of it.
    applyStimulus(0, 0, 1, 1, 5'd1, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
    applyStimulus(0, 0, 1, 1, 5'd2, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
    applyStimulus(0, 0, 1, 1, 5'd2, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
    applyStimulus(0, 0, 1, 1, 5'd10, 0, 5'd0, 1, 5'd2, 0, 5'd0);
    checkOutput("pre-reset busy", busy, 32'h0000_0006);
    checkOutput("pre-reset stall", {31'd0, stall_d}, 32'd1);
    tick();
    applyStimulus(1, 0, 1, 1, 5'd3, 0, 5'd0, 1, 5'd2, 1, 5'd10);
    checkOutput("reset-cycle busy", busy, 32'h0000_0406);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd2, 0, 5'd0, 1, 5'd2, 1, 5'd10);
    checkOutput("post-reset busy", busy, 32'd0);
    checkOutput("post-reset stall", {31'd0, stall_d}, 32'd0);
    checkOutput("post-reset ready", {31'd0, issue_ready}, 32'd1);
    tick();

    // Issue to $8 and release it by writeback.
    applyStimulus(0, 0, 1, 1, 5'd8, 0, 5'd0, 1, 5'd8, 0, 5'd0);
    checkOutput("same-cycle issue stall", {31'd0, stall_d}, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 5'd8, 0, 5'd0);
    checkOutput("r8 stall", {31'd0, stall_d}, 32'd1);
    checkOutput("r8 busy", {31'd0, busy[8]}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 5'd8, 0, 5'd0, 1, 5'd8);
    checkOutput("r8 retire stall", {31'd0, stall_d}, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 5'd8, 0, 5'd0);
    checkOutput("r8 busy after retire", {31'd0, busy[8]}, 32'd0);
    tick();

    // Saturate $9, get refused, then drain.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      tick();
    end
    applyStimulus(0, 0, 1, 1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    checkOutput("r9 full ready", {31'd0, issue_ready}, 32'd0);
    checkOutput("model r9 count", pend[9], 32'd3);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd9, 1, 5'd9, 0, 5'd0, 0, 5'd0);
    checkOutput("r9 retire-cycle ready", {31'd0, issue_ready}, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd9, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    checkOutput("r9 ready after retire", {31'd0, issue_ready}, 32'd1);
    checkOutput("model r9 after retire", pend[9], 32'd2);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 5'd9, 0, 5'd0, 1, 5'd9);
    checkOutput("r9 two left stall", {31'd0, stall_d}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 5'd9, 0, 5'd0, 1, 5'd9);
    checkOutput("r9 last retire stall", {31'd0, stall_d}, 32'd0);
    tick();
    idle();
    checkOutput("r9 busy drained", {31'd0, busy[9]}, 32'd0);
    tick();

    // Simultaneous issue/retire on the same and on different registers.
    applyStimulus(0, 0, 1, 1, 5'd6, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
    applyStimulus(0, 0, 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
    applyStimulus(0, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, 0, 5'd0); tick();
    applyStimulus(0, 0, 1, 1, 5'd5, 1, 5'd6, 0, 5'd0, 0, 5'd0);
    checkOutput("model r5 hold", pend[5], 32'd1);
    checkOutput("r5 busy hold", {31'd0, busy[5]}, 32'd1);
    tick();
    idle();
    checkOutput("model r5 inc", pend[5], 32'd2);
    checkOutput("r6 busy dec", {31'd0, busy[6]}, 32'd0);
    tick();

    // Register $0 traffic, underflow attempt, and a non-writing issue.
    applyStimulus(0, 0, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 5'd0);
    checkOutput("r0 stall", {31'd0, stall_d}, 32'd0);
    checkOutput("r0 ready", {31'd0, issue_ready}, 32'd1);
    tick();
    applyStimulus(0, 0, 1, 0, 5'd11, 1, 5'd3, 1, 5'd3, 0, 5'd0);
    checkOutput("r3 underflow stall", {31'd0, stall_d}, 32'd0);
    tick();
    idle();
    checkOutput("r0 busy", {31'd0, busy[0]}, 32'd0);
    checkOutput("r3 busy", {31'd0, busy[3]}, 32'd0);
    checkOutput("r11 no regwrite", {31'd0, busy[11]}, 32'd0);
    checkOutput("model r3", pend[3], 32'd0);
    tick();

    // Flush with traffic in the same cycle.
    applyStimulus(0, 0, 1, 1, 5'd4, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
    applyStimulus(0, 0, 1, 1, 5'd4, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 5'd4, 0, 5'd0);
    checkOutput("r4 stall", {31'd0, stall_d}, 32'd1);
    tick();
    applyStimulus(0, 1, 1, 1, 5'd7, 1, 5'd5, 0, 5'd0, 0, 5'd0);
    checkOutput("model r4 before flush", pend[4], 32'd2);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 5'd4, 1, 5'd7);
    checkOutput("flush busy", busy, 32'd0);
    checkOutput("flush stall", {31'd0, stall_d}, 32'd0);
`ifdef SCOREBOARD_STATS_EN
    checkOutput("stall_cnt kept", {31'd0, stall_cnt != 32'd0}, 32'd1);
    checkOutput("max_pend_hit sticky", {31'd0, max_pend_hit}, 32'd1);
`endif
    tick();
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
